// File: rtl/cvt_arbiter_if.sv
// cvt_arbiter_if: bundles the two request ports, the shared conversion
// datapath port and the response port of cvt_arbiter.
// master = arbiter side, slave = requesters / datapath / consumer side.
interface cvt_arbiter_if #(
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_op;
    logic [31:0]      req0_src;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_op;
    logic [31:0]      req1_src;
    logic [TAG_W-1:0] req1_tag;

    logic             cvt_op;
    logic [31:0]      cvt_src;
    logic [31:0]      cvt_res;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_res;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_id;
    logic             busy;

    modport master (
        input  req0_valid, req0_op, req0_src, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_src, req1_tag,
        output req1_ready,
        output cvt_op, cvt_src,
        input  cvt_res,
        output rsp_valid, rsp_res, rsp_tag, rsp_id, busy,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_op, req0_src, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_src, req1_tag,
        input  req1_ready,
        input  cvt_op, cvt_src,
        output cvt_res,
        input  rsp_valid, rsp_res, rsp_tag, rsp_id, busy,
        output rsp_ready
    );
endinterface

// File: rtl/cvt_arbiter.sv
// cvt_arbiter: round-robin arbiter sharing one combinational ftoi/itof
// datapath between two requesters. A granted operand is held on the
// datapath for LAT cycles, the result is captured and returned with the
// requester's tag and index over a valid/ready response port.
// Optional build macro CVT_ARB_B2B_EN: accept the next request on the
// response handshake edge (DONE -> RUN directly).
module cvt_arbiter #(
    parameter int TAG_W = 5,
    parameter int LAT   = 1
) (
    input  logic          clk,
    input  logic          rstn,
    cvt_arbiter_if.master bus
);

    // Guard against LAT=0 so the counter width below stays legal.
    localparam int               CNT_W    = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("cvt_arbiter: LAT must be in the range 1..8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_grant_reg;

    logic             iss_op_reg;
    logic [31:0]      iss_src_reg;
    logic [TAG_W-1:0] iss_tag_reg;
    logic             iss_id_reg;

    logic [31:0]      rsp_res_reg;
    logic [TAG_W-1:0] rsp_tag_reg;
    logic             rsp_id_reg;

    logic             grant;
    logic             accept_ok;
    logic             accept;
    logic             capture;

    // Round-robin pick: a lone requester wins, on a tie the one not served last.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_reg;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Requests are taken in IDLE (and on the handshake edge in back-to-back
    // mode); readies are forced low while reset is asserted.
`ifdef CVT_ARB_B2B_EN
    assign accept_ok = rstn && ((state_reg == IDLE) ||
                                (state_reg == DONE && bus.rsp_ready));
`else
    assign accept_ok = rstn && (state_reg == IDLE);
`endif

    assign bus.req0_ready = accept_ok && bus.req0_valid && !grant;
    assign bus.req1_ready = accept_ok && bus.req1_valid &&  grant;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign capture        = (state_reg == RUN) && (cnt_reg == CNT_LAST);

    assign bus.cvt_op    = iss_op_reg;
    assign bus.cvt_src   = iss_src_reg;
    assign bus.rsp_valid = (state_reg == DONE);
    assign bus.rsp_res   = rsp_res_reg;
    assign bus.rsp_tag   = rsp_tag_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.busy      = (state_reg != IDLE);

    // Next-state logic; accept is only ever high in DONE for back-to-back builds.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next = accept ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Issue registers drive the datapath and keep the last operand between jobs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            iss_op_reg     <= 1'b0;
            iss_src_reg    <= 32'h0;
            iss_tag_reg    <= '0;
            iss_id_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            iss_op_reg     <= grant ? bus.req1_op  : bus.req0_op;
            iss_src_reg    <= grant ? bus.req1_src : bus.req0_src;
            iss_tag_reg    <= grant ? bus.req1_tag : bus.req0_tag;
            iss_id_reg     <= grant;
            last_grant_reg <= grant;
        end
    end

    // Hold counter: restarts on accept, stops at LAT-1 so it never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
        end else if (state_reg == RUN && cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Capture the datapath result once the operand has been held LAT cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_res_reg <= 32'h0;
            rsp_tag_reg <= '0;
            rsp_id_reg  <= 1'b0;
        end else if (capture) begin
            rsp_res_reg <= bus.cvt_res;
            rsp_tag_reg <= iss_tag_reg;
            rsp_id_reg  <= iss_id_reg;
        end
    end

endmodule

// File: tb/tb_cvt_arbiter.sv
// tb_cvt_arbiter: drives two arbiters (LAT=1 and LAT=3) in lockstep with the
// same directed and random request streams, and compares every output each
// cycle against a transaction-level timeline model of the arbiter.
module tb_cvt_arbiter;

    localparam int TAG_W = 5;
`ifdef CVT_ARB_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // requester / consumer intent (copied to the DUT pins at each negedge)
    logic [1:0]       p_valid [2];
    logic [1:0]       p_op    [2];
    logic [31:0]      p_src   [2][2];
    logic [TAG_W-1:0] p_tag   [2][2];
    logic             p_rdy   [2];
    bit               rst_drive;
    bit               auto_refill;

    // values actually on the DUT input pins
    logic [1:0]       in_valid [2];
    logic [1:0]       in_op    [2];
    logic [31:0]      in_src   [2][2];
    logic [TAG_W-1:0] in_tag   [2][2];
    logic             in_rdy   [2];

    // observed DUT outputs
    logic [1:0]       o_ready [2];
    logic             o_rv [2], o_busy [2], o_cop [2], o_id [2];
    logic [31:0]      o_csrc [2], o_res [2];
    logic [TAG_W-1:0] o_tag [2];

    // timeline model: one job in flight, response visible from m_rdy onward
    bit               m_job  [2];
    int               m_rdy  [2];
    logic [31:0]      m_res  [2];
    logic [TAG_W-1:0] m_tag  [2];
    logic             m_id   [2];
    logic             m_last [2];
    logic             m_lop  [2];
    logic [31:0]      m_lsrc [2];

    // event records observed on the DUT
    int               acc_n [2];
    int               acc_cyc [2][16];
    logic             acc_id  [2][16];
    int               hs_n [2];
    int               hs_cyc [2][16];
    logic [31:0]      hs_res [2][16];
    logic [TAG_W-1:0] hs_tag [2][16];
    logic             hs_id  [2][16];

    // ---------------- conversion reference ----------------
    function automatic logic [31:0] f_itof(input logic [31:0] x);
        logic [63:0] d;
        logic [24:0] m;
        logic [7:0]  e;
        logic        g, s;
        if (x == 32'h0) return 32'h0;
        d = $realtobits($itor($signed(x)));
        e = 8'(int'(d[62:52]) - 1023 + 127);
        m = {2'b01, d[51:29]};
        g = d[28];
        s = |d[27:0];
        if (g && (s || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 8'd1;
        end
        return {d[63], e, m[22:0]};
    endfunction

    function automatic logic [31:0] f_ftoi(input logic [31:0] x);
        logic [63:0] d;
        int          r;
        if (x[30:23] == 8'h0) return 32'h0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        r = $rtoi($bitstoreal(d));
        return 32'(r);
    endfunction

    function automatic logic [31:0] f_ref(input logic op, input logic [31:0] src);
        return op ? f_itof(src) : f_ftoi(src);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // ---------------- DUTs ----------------
    cvt_arbiter_if #(.TAG_W(TAG_W)) bus0 ();
    cvt_arbiter_if #(.TAG_W(TAG_W)) bus1 ();

    cvt_arbiter #(.TAG_W(TAG_W), .LAT(1)) dut0 (.clk(clk), .rstn(rstn), .bus(bus0.master));
    cvt_arbiter #(.TAG_W(TAG_W), .LAT(3)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1.master));

    assign bus0.req0_valid = in_valid[0][0];
    assign bus0.req0_op    = in_op[0][0];
    assign bus0.req0_src   = in_src[0][0];
    assign bus0.req0_tag   = in_tag[0][0];
    assign bus0.req1_valid = in_valid[0][1];
    assign bus0.req1_op    = in_op[0][1];
    assign bus0.req1_src   = in_src[0][1];
    assign bus0.req1_tag   = in_tag[0][1];
    assign bus0.rsp_ready  = in_rdy[0];
    assign bus0.cvt_res    = f_ref(bus0.cvt_op, bus0.cvt_src);

    assign bus1.req0_valid = in_valid[1][0];
    assign bus1.req0_op    = in_op[1][0];
    assign bus1.req0_src   = in_src[1][0];
    assign bus1.req0_tag   = in_tag[1][0];
    assign bus1.req1_valid = in_valid[1][1];
    assign bus1.req1_op    = in_op[1][1];
    assign bus1.req1_src   = in_src[1][1];
    assign bus1.req1_tag   = in_tag[1][1];
    assign bus1.rsp_ready  = in_rdy[1];
    assign bus1.cvt_res    = f_ref(bus1.cvt_op, bus1.cvt_src);

    assign o_ready[0] = {bus0.req1_ready, bus0.req0_ready};
    assign o_rv[0]    = bus0.rsp_valid;
    assign o_busy[0]  = bus0.busy;
    assign o_cop[0]   = bus0.cvt_op;
    assign o_csrc[0]  = bus0.cvt_src;
    assign o_res[0]   = bus0.rsp_res;
    assign o_tag[0]   = bus0.rsp_tag;
    assign o_id[0]    = bus0.rsp_id;

    assign o_ready[1] = {bus1.req1_ready, bus1.req0_ready};
    assign o_rv[1]    = bus1.rsp_valid;
    assign o_busy[1]  = bus1.busy;
    assign o_cop[1]   = bus1.cvt_op;
    assign o_csrc[1]  = bus1.cvt_src;
    assign o_res[1]   = bus1.rsp_res;
    assign o_tag[1]   = bus1.rsp_tag;
    assign o_id[1]    = bus1.rsp_id;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rnd_src(input logic op);
        logic [31:0] v;
        v = $urandom;
        if (!op) v[30:23] = 8'($urandom_range(157, 120));
        return v;
    endfunction

    task automatic post(input int k, input int n, input logic op,
                        input logic [31:0] src, input logic [TAG_W-1:0] tag);
        p_valid[k][n]  = 1'b1;
        p_op[k][n]     = op;
        p_src[k][n]    = src;
        p_tag[k][n]    = tag;
    endtask

    task automatic new_req(input int k, input int n);
        logic op;
        op = 1'($urandom_range(1));
        post(k, n, op, rnd_src(op), TAG_W'($urandom));
    endtask

    task automatic clear_rec();
        for (int k = 0; k < 2; k++) begin
            acc_n[k] = 0;
            hs_n[k]  = 0;
        end
    endtask

    // Compare one instance against the model for the current cycle, then advance the model.
    task automatic eval(input int k);
        string      pfx;
        bit         rv, can;
        logic       g;
        logic [1:0] er;
        int         lat;
        lat = lat_of(k);
        pfx = $sformatf("L%0d", lat);
        if (!rst_drive) begin
            check({pfx, " rst ready"},  32'(o_ready[k]), 32'h0);
            check({pfx, " rst rsp_valid"}, 32'(o_rv[k]), 32'h0);
            check({pfx, " rst busy"},   32'(o_busy[k]), 32'h0);
            check({pfx, " rst cvt_op"}, 32'(o_cop[k]), 32'h0);
            check({pfx, " rst cvt_src"}, o_csrc[k], 32'h0);
            check({pfx, " rst rsp_res"}, o_res[k], 32'h0);
            check({pfx, " rst rsp_tag"}, 32'(o_tag[k]), 32'h0);
            check({pfx, " rst rsp_id"}, 32'(o_id[k]), 32'h0);
            m_job[k]  = 1'b0;
            m_last[k] = 1'b1;
            m_lop[k]  = 1'b0;
            m_lsrc[k] = 32'h0;
            return;
        end
        if (o_ready[k] != 2'b00 && acc_n[k] < 16) begin
            acc_cyc[k][acc_n[k]] = cyc;
            acc_id[k][acc_n[k]]  = o_ready[k][1];
            acc_n[k]++;
        end
        if (o_rv[k] && in_rdy[k] && hs_n[k] < 16) begin
            hs_cyc[k][hs_n[k]] = cyc;
            hs_res[k][hs_n[k]] = o_res[k];
            hs_tag[k][hs_n[k]] = o_tag[k];
            hs_id[k][hs_n[k]]  = o_id[k];
            hs_n[k]++;
        end
        rv  = m_job[k] && (cyc >= m_rdy[k]);
        can = !m_job[k] || (B2B && rv && in_rdy[k]);
        g   = (in_valid[k] == 2'b11) ? !m_last[k] : in_valid[k][1];
        er  = 2'b00;
        if (can && in_valid[k][g]) er[g] = 1'b1;
        check({pfx, " ready"},     32'(o_ready[k]), 32'(er));
        check({pfx, " rsp_valid"}, 32'(o_rv[k]),    32'(rv));
        check({pfx, " busy"},      32'(o_busy[k]),  32'(m_job[k]));
        check({pfx, " cvt_op"},    32'(o_cop[k]),   32'(m_lop[k]));
        check({pfx, " cvt_src"},   o_csrc[k],       m_lsrc[k]);
        if (rv) begin
            check({pfx, " rsp_res"}, o_res[k],        m_res[k]);
            check({pfx, " rsp_tag"}, 32'(o_tag[k]),   32'(m_tag[k]));
            check({pfx, " rsp_id"},  32'(o_id[k]),    32'(m_id[k]));
        end
        if (rv && in_rdy[k]) m_job[k] = 1'b0;
        if (er != 2'b00) begin
            m_job[k]  = 1'b1;
            m_rdy[k]  = cyc + lat + 1;
            m_res[k]  = f_ref(in_op[k][g], in_src[k][g]);
            m_tag[k]  = in_tag[k][g];
            m_id[k]   = g;
            m_last[k] = g;
            m_lop[k]  = in_op[k][g];
            m_lsrc[k] = in_src[k][g];
            p_valid[k][g] = 1'b0;
            if (auto_refill) new_req(k, int'(g));
        end
    endtask

    // One clock cycle: apply intent at the falling edge, then check both instances.
    task automatic step();
        @(negedge clk);
        rstn = rst_drive;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = p_valid[k];
            in_op[k]    = p_op[k];
            in_rdy[k]   = p_rdy[k];
            for (int n = 0; n < 2; n++) begin
                in_src[k][n] = p_src[k][n];
                in_tag[k][n] = p_tag[k][n];
            end
        end
        #1;
        for (int k = 0; k < 2; k++) eval(k);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic bit both_acc(input int n);
        return acc_n[0] >= n && acc_n[1] >= n;
    endfunction

    function automatic bit both_hs(input int n);
        return hs_n[0] >= n && hs_n[1] >= n;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int start;
        string pfx;
        rst_drive   = 1'b0;
        auto_refill = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p_valid[k] = 2'b00;
            p_op[k]    = 2'b00;
            p_rdy[k]   = 1'b1;
            for (int n = 0; n < 2; n++) begin
                p_src[k][n] = 32'h0;
                p_tag[k][n] = '0;
            end
        end
        clear_rec();

        // reset state
        steps(3);
        rst_drive = 1'b1;
        steps(1);

        // req0 itof 5, tag 3
        clear_rec();
        for (int k = 0; k < 2; k++) post(k, 0, 1'b1, 32'h0000_0005, 5'd3);
        start = cyc;
        for (int i = 0; i < 20 && !both_hs(1); i++) step();
        steps(2);
        for (int k = 0; k < 2; k++) begin
            pfx = $sformatf("L%0d", lat_of(k));
            check({pfx, " itof5 seen"}, 32'(hs_n[k]), 32'd1);
            check({pfx, " itof5 accept cyc"}, 32'(acc_cyc[k][0] - start), 32'd0);
            check({pfx, " itof5 latency"}, 32'(hs_cyc[k][0] - acc_cyc[k][0]), 32'(lat_of(k) + 1));
            check({pfx, " itof5 res"}, hs_res[k][0], 32'h40A0_0000);
            check({pfx, " itof5 tag"}, 32'(hs_tag[k][0]), 32'd3);
            check({pfx, " itof5 id"}, 32'(hs_id[k][0]), 32'd0);
            check({pfx, " itof5 idle"}, 32'(o_busy[k]), 32'd0);
        end

        // req1 ftoi pi, tag 7
        clear_rec();
        for (int k = 0; k < 2; k++) post(k, 1, 1'b0, 32'h4049_0FDB, 5'd7);
        for (int i = 0; i < 20 && !both_hs(1); i++) step();
        steps(2);
        for (int k = 0; k < 2; k++) begin
            pfx = $sformatf("L%0d", lat_of(k));
            check({pfx, " ftoi seen"}, 32'(hs_n[k]), 32'd1);
            check({pfx, " ftoi res"}, hs_res[k][0], 32'h0000_0003);
            check({pfx, " ftoi tag"}, 32'(hs_tag[k][0]), 32'd7);
            check({pfx, " ftoi id"}, 32'(hs_id[k][0]), 32'd1);
        end

        // round-robin with both requesters continuously valid from reset
        rst_drive = 1'b0;
        steps(2);
        rst_drive = 1'b1;
        clear_rec();
        auto_refill = 1'b1;
        for (int k = 0; k < 2; k++) begin
            new_req(k, 0);
            new_req(k, 1);
        end
        for (int i = 0; i < 60 && !both_acc(4); i++) step();
        auto_refill = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pfx = $sformatf("L%0d", lat_of(k));
            check({pfx, " rr count"}, 32'(acc_n[k] >= 4), 32'd1);
            for (int i = 0; i < 4; i++)
                check($sformatf("%s rr id%0d", pfx, i), 32'(acc_id[k][i]), 32'(i % 2));
            for (int i = 1; i < 4; i++)
                check($sformatf("%s rr gap%0d", pfx, i), 32'(acc_cyc[k][i] - acc_cyc[k][i-1]),
                      32'(lat_of(k) + (B2B ? 1 : 2)));
        end
        steps(30);

        // consumer stall in DONE with another request waiting
        clear_rec();
        for (int k = 0; k < 2; k++) begin
            p_rdy[k] = 1'b0;
            post(k, 0, 1'b1, rnd_src(1'b1), 5'd9);
            post(k, 1, 1'b0, rnd_src(1'b0), 5'd10);
        end
        steps(9);
        for (int k = 0; k < 2; k++) begin
            pfx = $sformatf("L%0d", lat_of(k));
            check({pfx, " stall valid"}, 32'(o_rv[k]), 32'd1);
            check({pfx, " stall no hs"}, 32'(hs_n[k]), 32'd0);
            check({pfx, " stall one accept"}, 32'(acc_n[k]), 32'd1);
            p_rdy[k] = 1'b1;
        end
        steps(30);

        // reset while a job is in RUN
        clear_rec();
        for (int k = 0; k < 2; k++) post(k, 1, 1'b1, rnd_src(1'b1), 5'd12);
        for (int i = 0; i < 10 && !both_acc(1); i++) step();
        rst_drive = 1'b0;
        for (int k = 0; k < 2; k++) begin
            post(k, 0, 1'b0, rnd_src(1'b0), 5'd1);
            post(k, 1, 1'b1, rnd_src(1'b1), 5'd2);
        end
        steps(3);
        rst_drive = 1'b1;
        clear_rec();
        start = cyc;
        for (int i = 0; i < 10 && !both_acc(1); i++) step();
        for (int k = 0; k < 2; k++) begin
            pfx = $sformatf("L%0d", lat_of(k));
            check({pfx, " post-rst accept cyc"}, 32'(acc_cyc[k][0] - start), 32'd0);
            check({pfx, " post-rst first id"}, 32'(acc_id[k][0]), 32'd0);
            check({pfx, " post-rst no stale rsp"}, 32'(hs_n[k]), 32'd0);
        end
        steps(30);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < 2; n++)
                    if (!p_valid[k][n] && $urandom_range(2) == 0) new_req(k, n);
                p_rdy[k] = ($urandom_range(3) != 0);
            end
            step();
        end
        for (int k = 0; k < 2; k++) p_rdy[k] = 1'b1;
        steps(40);
        for (int k = 0; k < 2; k++)
            check($sformatf("L%0d drained", lat_of(k)), 32'(o_busy[k]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cvt_arbiter.md
Name: cvt_arbiter

Overview:
- Shares one combinational float/int conversion datapath (ftoi/itof) between two requesters, e.g. integer pipeline and FPU pipeline.
- Grants one request at a time using round-robin priority.
- Holds the granted operand stable on the datapath inputs for LAT cycles, then captures the result.
- Returns the result with the requester's tag and id over a valid/ready response port.

Parameters:
- TAG_W, 5, width of destination-register tag carried with each request.
- LAT, 1, number of cycles the operand is held on the datapath before the result is captured. Legal range 1..8; LAT=0 is illegal and must be rejected by an elaboration-time assertion.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_op  in  1  0 = ftoi, 1 = itof.
- req0_src  in  32  operand.
- req0_tag  in  TAG_W  destination tag.
- req1_valid, req1_ready, req1_op, req1_src, req1_tag: same as req0_*, for requester 1.
- cvt_op  out  1  operation select to shared datapath.
- cvt_src  out  32  operand to shared datapath.
- cvt_res  in  32  datapath result; a combinational function of cvt_op/cvt_src.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_res  out  32  captured result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_id  out  1  requester index of the completed request.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; all outputs = 0; cycle counter = 0.
  - Round-robin pointer last_grant = 1, so req0 wins the first tie.
  - Any in-flight operation is discarded; no response is emitted for it.
- Grant (combinational):
  - Only one valid request: grant goes to that requester.
  - Both valid: grant goes to the requester != last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high in any cycle.
- IDLE:
  - Accept edge (any reqN_valid && reqN_ready): latch op/src/tag/id into issue registers, set last_grant = id, clear counter, go to RUN.
- RUN:
  - cvt_op/cvt_src are driven from the issue registers and held stable.
  - Counter increments each edge.
  - At the edge where counter == LAT-1: rsp_res <= cvt_res, rsp_tag/rsp_id <= issue values, go to DONE.
  - With LAT=1, the capture happens on the first edge after accept.
- DONE:
  - rsp_valid = 1; rsp_res, rsp_tag and rsp_id are held stable until handshake.
  - On rsp_valid && rsp_ready: go to IDLE and deassert rsp_valid on that edge.
  - No request is accepted while in DONE (base build).
- Timing:
  - Accept at edge T gives rsp_valid high from after edge T+LAT.
  - Minimum initiation interval = LAT+2 cycles.
- cvt_op/cvt_src:
  - Hold the last issued values in IDLE and DONE; they are 0 after reset.
  - The datapath output is ignored outside the capture edge.
- Requests not granted stay pending; requesters must keep valid/op/src/tag stable until ready.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Counter width = clog2(LAT+1); it never wraps because RUN exits at LAT-1.

Optional Feature:
- Macro: CVT_ARB_B2B_EN.
- Defined:
  - In DONE, when rsp_ready=1 and a request is valid, that request is granted (same round-robin rule) and accepted on the handshake edge.
  - reqN_ready may therefore be high in DONE under that condition.
  - State goes DONE -> RUN directly; initiation interval becomes LAT+1.
- Undefined:
  - reqN_ready = 0 in DONE.
  - DONE always returns to IDLE first.

Test Plan:
- LAT=1, req0 itof src=0x00000005 tag=3, rsp_ready=1 -> req0_ready at cycle 0, rsp_valid after edge 1, rsp_res=0x40A00000, rsp_tag=3, rsp_id=0, busy back to 0 after handshake.
- LAT=1, req1 ftoi src=0x40490FDB tag=7 -> rsp_res=0x00000003, rsp_id=1.
- From reset, req0 and req1 both held valid continuously -> grant order 0,1,0,1; responses every 3 cycles (every 2 with CVT_ARB_B2B_EN).
- rsp_ready=0 for 5 cycles while in DONE -> rsp_valid/rsp_res/rsp_tag held constant; req0_ready=req1_ready=0 throughout.
- LAT=3, single request accepted at edge T -> cvt_src stable for 3 cycles; rsp_valid first high after edge T+3, not earlier.
- rstn pulled low mid-RUN -> all outputs 0 immediately; after release, a simultaneous req0/req1 grants req0 first; no stale response appears.
